mem_port_arbiter: RTL and testbench

- Shares one single-ported unified 16-bit instruction/data memory between two requesters: the fetch stage (read only) and the memory stage (load or store).
- Sequences each access over a fixed memory latency.
- Returns a one-cycle acknowledge with the read data.
- Drives the pipeline-wide stall while any request is outstanding.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_lat_cnt.sv | 38 +++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

endpackage

// File: rtl/mem_port_arbiter_lat_cnt.sv
// Loadable down-counter that times one memory access; stops at zero and flags it.
module mem_lat_cnt
    import mem_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and memory-stage accesses onto one single-ported memory and stalls the pipeline meanwhile.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LAT = 2,
    parameter int AW  = 16,
    parameter int DW  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hlt,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_re,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LAT - 1);

    arb_state_e state_q;
    arb_state_e state_d;

    logic          port_q;
    logic          op_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;

    logic             d_req;
    logic             f_req;
    logic             grant;
    logic             busy;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt;

    // Data requests come from the older instruction, so they win over fetch.
    assign d_req = d_re | d_we;
    assign f_req = if_req & ~hlt;
    assign grant = (state_q == IDLE) && (d_req || f_req);
    assign busy  = (state_q == BUSY);

    mem_lat_cnt u_lat_cnt (
        .clk        (clk),
        .rst_i      (rst_n),
        .load_i     (grant),
        .en_i       (busy),
        .load_val_i (LAT_LOAD),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = BUSY;
            BUSY:    if (cnt_zero) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Writes fire only while the counter still holds its load value, giving one write per access.
    always_comb begin
        mem_re = 1'b0;
        mem_we = 1'b0;
        if_ack = 1'b0;
        d_ack  = 1'b0;
        case (state_q)
            BUSY: begin
                mem_re = (op_q == OP_RD);
                mem_we = (op_q == OP_WR) && (cnt == LAT_LOAD);
            end
            RESP: begin
                if_ack = (port_q == PORT_IF);
                d_ack  = (port_q == PORT_D);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            port_q  <= PORT_IF;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            port_q  <= d_req ? PORT_D : PORT_IF;
            op_q    <= (d_req && d_we) ? OP_WR : OP_RD;
            addr_q  <= d_req ? d_addr : if_addr;
            wdata_q <= d_req ? d_wdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (busy && cnt_zero && (op_q == OP_RD)) begin
            if (port_q == PORT_D) begin
                d_rdata_q <= mem_rdata;
            end else begin
                if_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    assign stall = ~rst_n & ((d_req & ~d_ack) | (f_req & ~if_ack));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (LAT=2 and LAT=3) driven by directed and random accesses against a memory model.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = 12;

    typedef struct {
        bit            port_d;
        logic [DW-1:0] rdata;
        int            ack_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 'h010) return 16'hA5C3;
        if (i == 'h200) return 16'h1234;
        return DW'(i * 40503) ^ 16'h5A5A;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 2 : 3;

        logic          rst_n   = 1'b1;
        logic          hlt     = 1'b0;
        logic          if_req  = 1'b0;
        logic          d_re    = 1'b0;
        logic          d_we    = 1'b0;
        logic [AW-1:0] if_addr = '0;
        logic [AW-1:0] d_addr  = '0;
        logic [DW-1:0] d_wdata = '0;
        logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
        logic [AW-1:0] mem_addr;
        logic          if_ack, d_ack, mem_re, mem_we, stall;
        bit            done = 1'b0;

        logic [DW-1:0] mem     [2**MW];
        int            wcnt    [2**MW];
        logic [DW-1:0] ref_mem [2**MW];
        logic [DW-1:0] last_if;
        logic [DW-1:0] last_d;
        exp_t          sb[$];

        mem_port_arbiter #(.LAT(LAT), .AW(AW), .DW(DW)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .hlt       (hlt),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_rdata  (if_rdata),
            .if_ack    (if_ack),
            .d_re      (d_re),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_rdata   (d_rdata),
            .d_ack     (d_ack),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_re    (mem_re),
            .mem_we    (mem_we),
            .mem_rdata (mem_rdata),
            .stall     (stall)
        );

        assign mem_rdata = mem_re ? mem[mem_addr[MW-1:0]] : 16'hDEAD;

        initial begin
            for (int i = 0; i < 2**MW; i++) begin
                mem[i]  = init_word(i);
                wcnt[i] = 0;
            end
            forever begin
                @(posedge clk);
                if (mem_we) begin
                    mem[mem_addr[MW-1:0]]  <= mem_wdata;
                    wcnt[mem_addr[MW-1:0]] <= wcnt[mem_addr[MW-1:0]] + 1;
                end
            end
        end

        always @(negedge clk) begin
            exp_t e;
            if (if_ack || d_ack) begin
                if (sb.size() == 0) begin
                    check("spurious_ack", 32'({if_ack, d_ack}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_port", 32'({if_ack, d_ack}), e.port_d ? 32'd1 : 32'd2);
                    check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                    check("ack_rdata", 32'(e.port_d ? d_rdata : if_rdata), 32'(e.rdata));
                end
            end
        end

        // d_op: 0 load, 1 store, 2 load+store (behaves as store). Called right after a rising edge.
        task automatic run_txn(input bit do_d, input int d_op, input logic [AW-1:0] da,
                               input logic [DW-1:0] dw, input bit do_f,
                               input logic [AW-1:0] fa, input bit hold_hlt);
            int            t0, d_ack_c, f_start, f_ack_c, end_c;
            bit            d_wr, f_live, er, ew, es, chk_a;
            logic [AW-1:0] ea;
            exp_t          e;
            t0      = cyc;
            d_wr    = (d_op != 0);
            f_live  = do_f && !hold_hlt;
            d_ack_c = t0 + LAT + 1;
            f_start = do_d ? d_ack_c + 1 : t0;
            f_ack_c = f_start + LAT + 1;
            end_c   = f_live ? f_ack_c : (do_d ? d_ack_c : t0 + 4);
            if (do_d) begin
                if (d_wr) ref_mem[da[MW-1:0]] = dw;
                else      last_d = ref_mem[da[MW-1:0]];
                e.port_d = 1'b1; e.rdata = last_d; e.ack_cyc = d_ack_c;
                sb.push_back(e);
            end
            if (f_live) begin
                last_if  = ref_mem[fa[MW-1:0]];
                e.port_d = 1'b0; e.rdata = last_if; e.ack_cyc = f_ack_c;
                sb.push_back(e);
            end
            hlt     = hold_hlt;
            d_re    = do_d && (d_op != 1);
            d_we    = do_d && (d_op != 0);
            d_addr  = da;
            d_wdata = dw;
            if_req  = do_f;
            if_addr = fa;
            for (int c = t0; c <= end_c; c++) begin
                @(negedge clk);
                er = 1'b0; ew = 1'b0; chk_a = 1'b0; ea = '0;
                if (do_d && c >= t0 + 1 && c <= t0 + LAT) begin
                    er = !d_wr; ew = d_wr && (c == t0 + 1); ea = da; chk_a = 1'b1;
                end
                if (f_live && c >= f_start + 1 && c <= f_start + LAT) begin
                    er = 1'b1; ea = fa; chk_a = 1'b1;
                end
                es = (do_d && c < d_ack_c) || (f_live && c < f_ack_c);
                check("stall", 32'(stall), 32'(es));
                check("mem_re", 32'(mem_re), 32'(er));
                check("mem_we", 32'(mem_we), 32'(ew));
                if (chk_a) check("mem_addr", 32'(mem_addr), 32'(ea));
                if (ew) check("mem_wdata", 32'(mem_wdata), 32'(dw));
                @(posedge clk); #1;
                if (do_d && c == d_ack_c) begin d_re = 1'b0; d_we = 1'b0; end
                if (f_live && c == f_ack_c) if_req = 1'b0;
            end
            if_req = 1'b0; hlt = 1'b0; d_re = 1'b0; d_we = 1'b0;
            check("if_rdata_hold", 32'(if_rdata), 32'(last_if));
            check("d_rdata_hold", 32'(d_rdata), 32'(last_d));
        endtask

        // Store aborted by a one-cycle reset in its second BUSY cycle.
        task automatic reset_mid_store(input logic [AW-1:0] da, input logic [DW-1:0] dw);
            int base;
            base    = wcnt[da[MW-1:0]];
            d_we    = 1'b1;
            d_addr  = da;
            d_wdata = dw;
            @(posedge clk); #1;
            @(negedge clk);
            check("rst_first_busy_we", 32'(mem_we), 32'd1);
            @(posedge clk); #1;
            rst_n  = 1'b1;
            if_req = 1'b1;
            @(negedge clk);
            check("rst_stall", 32'(stall), 32'd0);
            @(posedge clk); #1;
            rst_n = 1'b0; d_we = 1'b0; if_req = 1'b0;
            ref_mem[da[MW-1:0]] = dw;
            last_d  = '0;
            last_if = '0;
            @(negedge clk);
            check("rst_abort_we", 32'(mem_we), 32'd0);
            check("rst_abort_re", 32'(mem_re), 32'd0);
            check("rst_abort_ack", 32'({if_ack, d_ack}), 32'd0);
            check("rst_abort_addr", 32'(mem_addr), 32'd0);
            check("rst_abort_rdata", 32'(d_rdata), 32'd0);
            repeat (LAT + 2) begin @(posedge clk); #1; end
            check("rst_write_count", 32'(wcnt[da[MW-1:0]] - base), 32'd1);
        endtask

        initial begin
            int            op;
            bit            dd, ff, hh;
            logic [AW-1:0] ra, rf;
            for (int i = 0; i < 2**MW; i++) ref_mem[i] = init_word(i);
            last_if = '0;
            last_d  = '0;
            if_req  = 1'b1;
            d_re    = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            check("reset_stall", 32'(stall), 32'd0);
            check("reset_ctrl", 32'({if_ack, d_ack, mem_re, mem_we}), 32'd0);
            check("reset_mem_addr", 32'(mem_addr), 32'd0);
            check("reset_mem_wdata", 32'(mem_wdata), 32'd0);
            check("reset_rdata", 32'({if_rdata, d_rdata}), 32'd0);
            @(posedge clk); #1;
            rst_n = 1'b0; if_req = 1'b0; d_re = 1'b0;

            run_txn(1'b0, 0, '0, '0, 1'b1, 16'h0010, 1'b0);
            run_txn(1'b1, 0, 16'h0200, '0, 1'b1, 16'h0010, 1'b0);
            run_txn(1'b1, 1, 16'h0040, 16'hBEEF, 1'b0, '0, 1'b0);
            run_txn(1'b1, 0, 16'h0040, '0, 1'b0, '0, 1'b0);
            run_txn(1'b0, 0, '0, '0, 1'b1, 16'h0020, 1'b1);
            run_txn(1'b1, 0, 16'h0200, '0, 1'b1, 16'h0020, 1'b1);
            run_txn(1'b1, 2, 16'h0080, 16'h1357, 1'b0, '0, 1'b0);
            run_txn(1'b1, 0, 16'h0080, '0, 1'b0, '0, 1'b0);
            reset_mid_store(16'h0100, 16'hC0DE);
            run_txn(1'b1, 0, 16'h0100, '0, 1'b1, 16'h0100, 1'b0);

            for (int k = 0; k < 40; k++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                dd = 1'($urandom_range(0, 1));
                ff = 1'($urandom_range(0, 1));
                hh = ($urandom_range(0, 5) == 0);
                op = int'($urandom_range(0, 2));
                ra = AW'($urandom_range(0, 63));
                rf = AW'($urandom_range(0, 63));
                run_txn(dd, op, ra, DW'($urandom), ff, rf, hh);
            end
            repeat (4) begin @(posedge clk); #1; end
            check("scoreboard_empty", 32'(sb.size()), 32'd0);
            done = 1'b1;
        end
    end

    initial begin
        int waited;
        waited = 0;
        while (!(g_inst[0].done && g_inst[1].done) && waited < 20000) begin
            @(posedge clk);
            waited++;
        end
        check("run_complete", 32'(g_inst[0].done && g_inst[1].done), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
